// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and counter sizing.
package adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Digit counter width: max(1, clog2(n/d)).
    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned d);
        int unsigned k;
        k = n / d;
        if (k <= 1) begin
            return 1;
        end
        return $clog2(k);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle of the serial adder.
//   start, A, B, C_in, sub : request side, driven by the master
//   busy, done, S, C_out, V: status/result side, driven by the adder (slave)
interface serial_adder_if #(
    parameter int unsigned N = 32
) ();

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         C_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         C_out;
    logic         V;

    modport master (
        output start, A, B, C_in, sub,
        input  busy, done, S, C_out, V
    );

    modport slave (
        input  start, A, B, C_in, sub,
        output busy, done, S, C_out, V
    );

endinterface

// File: rtl/serial_adder_digit.sv
// digit_adder: combinational D-bit adder slice.
//   i_a, i_b, i_c_in : digit operands and carry-in
//   o_s              : digit sum
//   o_c_out          : carry out of bit D-1
//   o_c_msb          : carry into bit D-1 (for signed overflow)
module digit_adder #(
    parameter int unsigned D = 8
) (
    input  logic [D-1:0] i_a,
    input  logic [D-1:0] i_b,
    input  logic         i_c_in,
    output logic [D-1:0] o_s,
    output logic         o_c_out,
    output logic         o_c_msb
);

    logic [D:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + (D+1)'(i_c_in);
    assign o_s     = w_full[D-1:0];
    assign o_c_out = w_full[D];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the sum.
    assign o_c_msb = i_a[D-1] ^ i_b[D-1] ^ w_full[D-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: N-bit add/subtract computed D bits per clock (K = N/D digits).
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of serial_adder_if (start/A/B/C_in/sub in,
//              busy/done/S/C_out/V out; all outputs registered)
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned D = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);

    localparam int unsigned K  = N / D;
    localparam int unsigned CW = cnt_width(N, D);

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_last;

    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_c;
    logic [N-1:0]    r_s;
    logic            r_cout;
    logic            r_v;
    logic            r_busy;
    logic            r_done;

    logic [D-1:0]    w_sum;
    logic            w_cout;
    logic            w_cmsb;
    logic [N+D-1:0]  w_cat;

    // Low digit of the operand registers plus the rippled carry.
    digit_adder #(.D(D)) u_digit (
        .i_a     (r_a[D-1:0]),
        .i_b     (r_b[D-1:0]),
        .i_c_in  (r_c),
        .o_s     (w_sum),
        .o_c_out (w_cout),
        .o_c_msb (w_cmsb)
    );

    // New digit enters at the top of the result; after K shifts it is aligned.
    assign w_cat = {w_sum, r_s};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = (r_cnt == CW'(K - 1));
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_next   = ST_RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath, counter and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_s    <= '0;
            r_cout <= 1'b0;
            r_v    <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_RUN);
            r_done <= (w_next == ST_DONE);
            if (w_accept) begin
                r_a   <= bus.A;
                r_b   <= bus.B ^ {N{bus.sub}};
                r_c   <= bus.C_in;
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_a   <= r_a >> D;
                r_b   <= r_b >> D;
                r_c   <= w_cout;
                r_s   <= N'(w_cat >> D);
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cout <= w_cout;
                    r_v    <= w_cmsb ^ w_cout;
                end
            end
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.S     = r_s;
    assign bus.C_out = r_cout;
    assign bus.V     = r_v;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed N=32/D=8 tests plus a
// parameter sweep over (8,8), (8,1), (16,4) against a reference model.
module tb_serial_adder;

    typedef struct {
        int          id;
        int          lat;
        logic [31:0] s;
        logic        cout;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q32[$];
    exp_t qsw[$];

    serial_adder_if #(.N(32)) if32  ();
    serial_adder_if #(.N(8))  if88  ();
    serial_adder_if #(.N(8))  if81  ();
    serial_adder_if #(.N(16)) if164 ();

    serial_adder #(.N(32), .D(8)) u32  (.clk(clk), .rst(rst), .bus(if32.slave));
    serial_adder #(.N(8),  .D(8)) u88  (.clk(clk), .rst(rst), .bus(if88.slave));
    serial_adder #(.N(8),  .D(1)) u81  (.clk(clk), .rst(rst), .bus(if81.slave));
    serial_adder #(.N(16), .D(4)) u164 (.clk(clk), .rst(rst), .bus(if164.slave));

    // Sweep outputs gathered by id: 1=(8,8) 2=(8,1) 3=(16,4)
    logic        sw_done [1:3];
    logic [31:0] sw_s    [1:3];
    logic        sw_co   [1:3];
    logic        sw_v    [1:3];
    assign sw_done[1] = if88.done;  assign sw_s[1] = 32'(if88.S);  assign sw_co[1] = if88.C_out;  assign sw_v[1] = if88.V;
    assign sw_done[2] = if81.done;  assign sw_s[2] = 32'(if81.S);  assign sw_co[2] = if81.C_out;  assign sw_v[2] = if81.V;
    assign sw_done[3] = if164.done; assign sw_s[3] = 32'(if164.S); assign sw_co[3] = if164.C_out; assign sw_v[3] = if164.V;

    function automatic exp_t model(input int id, input int n, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sb, input int lat);
        exp_t        e;
        logic [33:0] mask;
        logic [33:0] lowm;
        logic [33:0] aa;
        logic [33:0] bb;
        logic [33:0] full;
        logic [33:0] part;
        logic        cmsb;
        mask = (34'd1 << n) - 34'd1;
        lowm = mask >> 1;
        aa   = {2'b00, a} & mask;
        bb   = (sb ? ~{2'b00, b} : {2'b00, b}) & mask;
        full = aa + bb + 34'(cin);
        part = (aa & lowm) + (bb & lowm) + 34'(cin);
        cmsb = part[n-1];
        e.id   = id;
        e.lat  = lat;
        e.s    = 32'(full & mask);
        e.cout = full[n];
        e.v    = cmsb ^ full[n];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sb);
        if32.A     = a;
        if32.B     = b;
        if32.C_in  = cin;
        if32.sub   = sb;
        if32.start = 1'b1;
        q32.push_back(model(0, 32, a, b, cin, sb, 5));
    endtask

    // Called in the cycle start is driven; returns in the done cycle.
    task automatic run32(input bit hold);
        exp_t e;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (!hold) if32.start = 1'b0;
            chk("busy32_run", 64'(if32.busy), 64'd1);
            chk("done32_run", 64'(if32.done), 64'd0);
        end
        step();
        chk("busy32_done", 64'(if32.busy), 64'd0);
        chk("done32_done", 64'(if32.done), 64'd1);
        if (q32.size() == 0) begin
            chk("q32_empty", 64'(q32.size()), 64'd1);
        end else begin
            e = q32.pop_front();
            chk("S32",    64'(if32.S),     64'(e.s));
            chk("Cout32", 64'(if32.C_out), 64'(e.cout));
            chk("V32",    64'(if32.V),     64'(e.v));
        end
    endtask

    task automatic sweep_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sb);
        exp_t e;
        if88.A  = a[7:0];  if88.B  = b[7:0];  if88.C_in  = cin; if88.sub  = sb; if88.start  = 1'b1;
        if81.A  = a[7:0];  if81.B  = b[7:0];  if81.C_in  = cin; if81.sub  = sb; if81.start  = 1'b1;
        if164.A = a[15:0]; if164.B = b[15:0]; if164.C_in = cin; if164.sub = sb; if164.start = 1'b1;
        // Pushed in expected completion order: K+1 = 2, 5, 9.
        qsw.push_back(model(1, 8,  a, b, cin, sb, 2));
        qsw.push_back(model(3, 16, a, b, cin, sb, 5));
        qsw.push_back(model(2, 8,  a, b, cin, sb, 9));
        for (int c = 1; c <= 20 && qsw.size() > 0; c++) begin
            step();
            if (c == 1) begin
                if88.start  = 1'b0;
                if81.start  = 1'b0;
                if164.start = 1'b0;
            end
            for (int id = 1; id <= 3; id++) begin
                if (sw_done[id]) begin
                    if (qsw.size() == 0) begin
                        chk("sw_spurious_done", 64'(id), 64'd0);
                    end else begin
                        e = qsw.pop_front();
                        chk("sw_id",   64'(id),         64'(e.id));
                        chk("sw_lat",  64'(c),          64'(e.lat));
                        chk("sw_S",    64'(sw_s[id]),   64'(e.s));
                        chk("sw_Cout", 64'(sw_co[id]),  64'(e.cout));
                        chk("sw_V",    64'(sw_v[id]),   64'(e.v));
                    end
                end
            end
        end
        if (qsw.size() != 0) begin
            chk("sw_timeout_pending", 64'(qsw.size()), 64'd0);
            qsw.delete();
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        if32.start = 1'b1; if32.A = '0; if32.B = '0; if32.C_in = 1'b0; if32.sub = 1'b0;
        if88.start = 1'b1; if88.A = '0; if88.B = '0; if88.C_in = 1'b0; if88.sub = 1'b0;
        if81.start = 1'b1; if81.A = '0; if81.B = '0; if81.C_in = 1'b0; if81.sub = 1'b0;
        if164.start = 1'b1; if164.A = '0; if164.B = '0; if164.C_in = 1'b0; if164.sub = 1'b0;

        // Reset held two cycles with start high
        step();
        step();
        chk("rst_busy", 64'(if32.busy),  64'd0);
        chk("rst_done", 64'(if32.done),  64'd0);
        chk("rst_S",    64'(if32.S),     64'd0);
        chk("rst_Cout", 64'(if32.C_out), 64'd0);
        chk("rst_V",    64'(if32.V),     64'd0);
        rst = 1'b0;
        if32.start = 1'b0; if88.start = 1'b0; if81.start = 1'b0; if164.start = 1'b0;
        step();

        // Basic add with carry rippling across a digit boundary
        drive32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run32(1'b0);
        step();

        // Full wrap, then back-to-back signed overflow
        drive32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run32(1'b0);
        drive32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run32(1'b0);
        if32.start = 1'b0;
        step();

        // Subtraction with and without borrow
        drive32(32'd5, 32'd7, 1'b1, 1'b1);
        run32(1'b0);
        drive32(32'd7, 32'd5, 1'b1, 1'b1);
        run32(1'b0);
        if32.start = 1'b0;
        step();

        // start held through RUN: re-accepted only in the done cycle
        drive32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        run32(1'b1);
        drive32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        run32(1'b0);
        step();
        chk("idle_busy", 64'(if32.busy), 64'd0);
        chk("idle_done", 64'(if32.done), 64'd0);
        step();
        chk("idle_done2", 64'(if32.done), 64'd0);

        // Reset in cycle 2 aborts the operation
        drive32(32'h0000_AAAA, 32'h0000_5555, 1'b0, 1'b0);
        step();
        if32.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q32.delete();
        chk("abort_busy", 64'(if32.busy),  64'd0);
        chk("abort_done", 64'(if32.done),  64'd0);
        chk("abort_S",    64'(if32.S),     64'd0);
        chk("abort_Cout", 64'(if32.C_out), 64'd0);
        chk("abort_V",    64'(if32.V),     64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_no_done", 64'(if32.done), 64'd0);
        end

        // Parameter sweep: directed corners then random operands
        sweep_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        sweep_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        sweep_op(32'h0000_8080, 32'h0000_8080, 1'b0, 1'b0);
        sweep_op(32'h0000_7F7F, 32'h0000_0101, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sweep_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
